// File: rtl/mpm_pkg.sv
// Shared sizing helpers and controller state for the LVT multiport RAM.
package mpm_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    function automatic int addr_w(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

    // One bit minimum so a single write port still has a legal LVT entry.
    function automatic int lvt_w(input int wports);
        return (wports > 1) ? $clog2(wports) : 1;
    endfunction

endpackage

// File: rtl/sdp_bank.sv
// Simple dual-port bank: one write port, one registered read port, read-first.
// Latency: read data one cycle after re; write visible to reads on the following cycle.
// Backpressure: none, accepts a read and a write every cycle.
module sdp_bank
    import mpm_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 256
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [addr_w(DEPTH)-1:0]  waddr,
    input  logic [WIDTH-1:0]          wdata,
    input  logic                      re,
    input  logic [addr_w(DEPTH)-1:0]  raddr,
    output logic [WIDTH-1:0]          rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Non-blocking read and write on one edge: a colliding read sees the old word.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/lvt_multiport_ram.sv
// Multiport RAM from WPORTS x RPORTS 1W1R banks steered by a live value table.
// Latency: rdata/rvalid one cycle after ren; writes visible the next cycle.
// Backpressure: busy during the post-reset clear walk, when wen/ren are ignored.
module lvt_multiport_ram
    import mpm_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 256,
    parameter int WPORTS = 2,
    parameter int RPORTS = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [WPORTS-1:0][addr_w(DEPTH)-1:0]  waddr,
    input  logic [WPORTS-1:0]                     wen,
    input  logic [WPORTS-1:0][WIDTH-1:0]          wdata,
    input  logic [RPORTS-1:0][addr_w(DEPTH)-1:0]  raddr,
    input  logic [RPORTS-1:0]                     ren,
    output logic [RPORTS-1:0][WIDTH-1:0]          rdata,
    output logic [RPORTS-1:0]                     rvalid,
    output logic                                  busy
);

    localparam int AW = addr_w(DEPTH);
    localparam int LW = lvt_w(WPORTS);

    state_t                      state;
    state_t                      state_nxt;
    logic [AW-1:0]               clr_addr;
    logic                        clearing;
    logic                        active;
    logic [WPORTS-1:0]           wr_go;
    logic [RPORTS-1:0]           rd_go;

    logic [WPORTS-1:0]           bank_we;
    logic [WPORTS-1:0][AW-1:0]   bank_waddr;
    logic [WPORTS-1:0][WIDTH-1:0] bank_wdata;
    logic [WIDTH-1:0]            bank_q [WPORTS][RPORTS];

    logic [LW-1:0]               lvt [DEPTH];
    logic [LW-1:0]               sel [RPORTS];
    logic [RPORTS-1:0]           pend;
    logic [RPORTS-1:0][WIDTH-1:0] hold;

    // rst gates both paths so nothing lands in storage on the reset cycle itself.
    assign clearing = (state == ST_CLEAR) && !rst;
    assign active   = (state == ST_IDLE) && !rst;
    assign wr_go    = active ? wen : '0;
    assign rd_go    = active ? ren : '0;
    assign busy     = (state == ST_CLEAR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_CLEAR: begin
                if (clr_addr == AW'(DEPTH - 1)) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clr_addr <= '0;
        end else if (state == ST_CLEAR) begin
            clr_addr <= clr_addr + AW'(1);
        end
    end

    // During clear every write port is hijacked to zero the current address.
    always_comb begin
        bank_we    = '0;
        bank_waddr = '0;
        bank_wdata = '0;
        for (int w = 0; w < WPORTS; w++) begin
            bank_we[w]    = clearing | wr_go[w];
            bank_waddr[w] = clearing ? clr_addr : waddr[w];
            bank_wdata[w] = clearing ? '0 : wdata[w];
        end
    end

    for (genvar gw = 0; gw < WPORTS; gw++) begin : g_wp
        for (genvar gr = 0; gr < RPORTS; gr++) begin : g_rp
            sdp_bank #(
                .WIDTH (WIDTH),
                .DEPTH (DEPTH)
            ) u_bank (
                .clk   (clk),
                .we    (bank_we[gw]),
                .waddr (bank_waddr[gw]),
                .wdata (bank_wdata[gw]),
                .re    (rd_go[gr]),
                .raddr (raddr[gr]),
                .rdata (bank_q[gw][gr])
            );
        end
    end

    // Ascending loop with non-blocking writes: highest port index wins a tie.
    // Lookups sample the pre-write entry, matching the read-first banks.
    always_ff @(posedge clk) begin
        if (clearing) begin
            lvt[clr_addr] <= '0;
        end else begin
            for (int w = 0; w < WPORTS; w++) begin
                if (wr_go[w]) begin
                    lvt[waddr[w]] <= LW'(w);
                end
            end
        end
        for (int r = 0; r < RPORTS; r++) begin
            if (rd_go[r]) begin
                sel[r] <= lvt[raddr[r]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= '0;
            hold <= '0;
        end else begin
            pend <= rd_go;
            for (int r = 0; r < RPORTS; r++) begin
                if (pend[r]) begin
                    hold[r] <= rdata[r];
                end
            end
        end
    end

    // Fresh bank data while valid, otherwise the last delivered word.
    always_comb begin
        rdata = hold;
        for (int r = 0; r < RPORTS; r++) begin
            if (pend[r]) begin
                rdata[r] = bank_q[sel[r]][r];
            end
        end
    end

    assign rvalid = pend;

endmodule

// File: tb/tb_lvt_multiport_ram.sv
// Directed bench for lvt_multiport_ram with default parameters (32b x 256, 2W2R).
module tb_lvt_multiport_ram;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0][7:0]  waddr;
    logic [1:0]       wen;
    logic [1:0][31:0] wdata;
    logic [1:0][7:0]  raddr;
    logic [1:0]       ren;
    logic [1:0][31:0] rdata;
    logic [1:0]       rvalid;
    logic             busy;

    int n_chk;
    int n_fail;

    lvt_multiport_ram dut (
        .clk    (clk),
        .rst    (rst),
        .waddr  (waddr),
        .wen    (wen),
        .wdata  (wdata),
        .raddr  (raddr),
        .ren    (ren),
        .rdata  (rdata),
        .rvalid (rvalid),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  wen;
        logic [7:0]  wa0;
        logic [31:0] wd0;
        logic [7:0]  wa1;
        logic [31:0] wd1;
        logic [1:0]  ren;
        logic [7:0]  ra0;
        logic [7:0]  ra1;
        logic [1:0]  xrv;
        logic [31:0] xd0;
        logic [31:0] xd1;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    function automatic vec_t mk(logic [1:0] w, logic [7:0] wa0, logic [31:0] wd0,
                                logic [7:0] wa1, logic [31:0] wd1, logic [1:0] r,
                                logic [7:0] ra0, logic [7:0] ra1, logic [1:0] xrv,
                                logic [31:0] xd0, logic [31:0] xd1);
        vec_t v;
        v.wen = w;   v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
        v.ren = r;   v.ra0 = ra0; v.ra1 = ra1;
        v.xrv = xrv; v.xd0 = xd0; v.xd1 = xd1;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        wen   = '0;
        ren   = '0;
        waddr = '0;
        raddr = '0;
        wdata = '0;
    endtask

    // Counts busy cycles (bounded); optionally pokes write/read near the end of the walk.
    task automatic wait_clear(output int n, output int rv_seen, input bit poke);
        n = 0;
        rv_seen = 0;
        while (busy === 1'b1 && n < 1000) begin
            if (rvalid !== 2'b00) rv_seen++;
            if (poke && n >= 250) begin
                wen      = 2'b01;
                waddr[0] = 8'd4;
                wdata[0] = 32'h77;
                ren      = 2'b11;
                raddr[0] = 8'd4;
                raddr[1] = 8'd4;
            end
            n++;
            @(posedge clk);
            @(negedge clk);
        end
        if (rvalid !== 2'b00) rv_seen++;
        idle_inputs();
    endtask

    task automatic read_pair(input logic [7:0] a0, input logic [7:0] a1,
                             input logic [31:0] e0, input logic [31:0] e1, input string name);
        raddr[0] = a0;
        raddr[1] = a1;
        ren      = 2'b11;
        @(posedge clk);
        @(negedge clk);
        ren = 2'b00;
        check({name, "_rvalid"}, {30'd0, rvalid}, 32'd3);
        check({name, "_rdata0"}, rdata[0], e0);
        check({name, "_rdata1"}, rdata[1], e1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int rv_a;
        int rv_b;
        n_chk  = 0;
        n_fail = 0;
        idle_inputs();
        rst = 1'b1;

        vecs[0]  = mk(2'b11, 8'd3, 32'hA5A5A5A5, 8'd7, 32'h12345678, 2'b00, 8'd0, 8'd0, 2'b00, 32'h0, 32'h0);
        vecs[1]  = mk(2'b00, 8'd0, 32'h0, 8'd0, 32'h0, 2'b11, 8'd3, 8'd7, 2'b11, 32'hA5A5A5A5, 32'h12345678);
        vecs[2]  = mk(2'b00, 8'd0, 32'h0, 8'd0, 32'h0, 2'b11, 8'd7, 8'd3, 2'b11, 32'h12345678, 32'hA5A5A5A5);
        vecs[3]  = mk(2'b00, 8'd0, 32'h0, 8'd0, 32'h0, 2'b00, 8'd0, 8'd0, 2'b00, 32'h12345678, 32'hA5A5A5A5);
        vecs[4]  = mk(2'b11, 8'd5, 32'h11, 8'd5, 32'h22, 2'b00, 8'd0, 8'd0, 2'b00, 32'h12345678, 32'hA5A5A5A5);
        vecs[5]  = mk(2'b00, 8'd0, 32'h0, 8'd0, 32'h0, 2'b11, 8'd5, 8'd5, 2'b11, 32'h22, 32'h22);
        vecs[6]  = mk(2'b01, 8'd9, 32'hAA, 8'd0, 32'h0, 2'b00, 8'd0, 8'd0, 2'b00, 32'h22, 32'h22);
        vecs[7]  = mk(2'b10, 8'd0, 32'h0, 8'd9, 32'hBB, 2'b00, 8'd0, 8'd0, 2'b00, 32'h22, 32'h22);
        vecs[8]  = mk(2'b00, 8'd0, 32'h0, 8'd0, 32'h0, 2'b01, 8'd9, 8'd0, 2'b01, 32'hBB, 32'h22);
        vecs[9]  = mk(2'b01, 8'd9, 32'hCC, 8'd0, 32'h0, 2'b00, 8'd0, 8'd0, 2'b00, 32'hBB, 32'h22);
        vecs[10] = mk(2'b00, 8'd0, 32'h0, 8'd0, 32'h0, 2'b10, 8'd0, 8'd9, 2'b10, 32'hBB, 32'hCC);
        vecs[11] = mk(2'b01, 8'd2, 32'h01, 8'd0, 32'h0, 2'b00, 8'd0, 8'd0, 2'b00, 32'hBB, 32'hCC);
        vecs[12] = mk(2'b10, 8'd0, 32'h0, 8'd2, 32'h02, 2'b11, 8'd2, 8'd2, 2'b11, 32'h01, 32'h01);
        vecs[13] = mk(2'b00, 8'd0, 32'h0, 8'd0, 32'h0, 2'b01, 8'd2, 8'd0, 2'b01, 32'h02, 32'h01);
        vecs[14] = mk(2'b00, 8'd0, 32'h0, 8'd0, 32'h0, 2'b11, 8'd5, 8'd3, 2'b11, 32'h22, 32'hA5A5A5A5);

        // Reset for one cycle, then the full clear walk with ignored traffic near its end.
        @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd1);
        check("rst_rvalid", {30'd0, rvalid}, 32'd0);
        check("rst_rdata0", rdata[0], 32'd0);
        check("rst_rdata1", rdata[1], 32'd0);
        rst = 1'b0;
        wait_clear(n, rv_a, 1'b1);
        check("clear_cycles", n, 32'd256);
        check("clear_rvalid_quiet", rv_a, 32'd0);
        read_pair(8'd0, 8'd255, 32'd0, 32'd0, "post_clear");
        read_pair(8'd4, 8'd4, 32'd0, 32'd0, "busy_write_ignored");

        for (int i = 0; i < NV; i++) begin
            wen      = vecs[i].wen;
            waddr[0] = vecs[i].wa0;
            wdata[0] = vecs[i].wd0;
            waddr[1] = vecs[i].wa1;
            wdata[1] = vecs[i].wd1;
            ren      = vecs[i].ren;
            raddr[0] = vecs[i].ra0;
            raddr[1] = vecs[i].ra1;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d_rvalid", i), {30'd0, rvalid}, {30'd0, vecs[i].xrv});
            check($sformatf("vec%0d_rdata0", i), rdata[0], vecs[i].xd0);
            check($sformatf("vec%0d_rdata1", i), rdata[1], vecs[i].xd1);
        end
        idle_inputs();

        // Reset arriving with a read, then again at clear address 100.
        wen      = 2'b10;
        waddr[1] = 8'd10;
        wdata[1] = 32'h55;
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        ren      = 2'b11;
        raddr[0] = 8'd10;
        raddr[1] = 8'd10;
        rst      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midop_rvalid", {30'd0, rvalid}, 32'd0);
        check("midop_busy", {31'd0, busy}, 32'd1);
        check("midop_rdata0", rdata[0], 32'd0);
        rst = 1'b0;
        idle_inputs();
        rv_a = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (rvalid !== 2'b00) rv_a++;
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midclear_busy", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        wait_clear(n, rv_b, 1'b0);
        check("midclear_cycles", n, 32'd256);
        check("midclear_rvalid_quiet", rv_a + rv_b, 32'd0);
        read_pair(8'd10, 8'd3, 32'd0, 32'd0, "midclear_mem");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
